// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/ERET sequencer: prioritises exception requests, drives the EPC hardware port,
// arbitrates software EPC writes, and sequences the pipeline flush and PC redirect.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  exc_vec,
  input  logic [31:0] pc_p,
  input  logic        bd_p,
  input  logic        eret,
  input  logic        mtc0_req,
  output logic        mtc0_ack,
  input  logic [31:0] epc_rdata,
  output logic        we_h,
  output logic [31:0] pc_h,
  output logic        bd_h,
  output logic        r_h,
  output logic        exl,
  output logic [4:0]  exccode,
  output logic        stall,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COMMIT,
    ERET_RD,
    FLUSH,
    REDIRECT
  } state_t;

  state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]  code_reg;
  logic [31:0] target_reg;

  logic [6:0]  exc_masked;
  logic        exc_valid;
  logic [4:0]  exc_code;

  // Interrupts are masked while already at exception level.
  assign exc_masked = exc_vec & {6'h3f, ~exl};
  assign exc_valid  = |exc_masked;

  always_comb begin
    exc_code = 5'd0;
    if      (exc_masked[0]) exc_code = 5'd0;
    else if (exc_masked[1]) exc_code = 5'd4;
    else if (exc_masked[3]) exc_code = 5'd10;
    else if (exc_masked[4]) exc_code = 5'd12;
    else if (exc_masked[5]) exc_code = 5'd8;
    else if (exc_masked[6]) exc_code = 5'd9;
    else if (exc_masked[2]) exc_code = 5'd5;
  end

  // Software writes only fire in cycles where no hardware EPC access can start.
  assign mtc0_ack = mtc0_req & (state == IDLE) & ~exc_valid & ~eret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      code_reg    <= 5'd0;
      target_reg  <= 32'd0;
      we_h        <= 1'b0;
      pc_h        <= 32'd0;
      bd_h        <= 1'b0;
      r_h         <= 1'b0;
      exl         <= 1'b0;
      exccode     <= 5'd0;
      stall       <= 1'b0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      we_h     <= 1'b0;
      pc_h     <= 32'd0;
      bd_h     <= 1'b0;
      r_h      <= 1'b0;
      redirect <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_valid) begin
            code_reg   <= exc_code;
            target_reg <= EXC_VECTOR;
            we_h       <= ~exl;
            pc_h       <= pc_p;
            bd_h       <= bd_p;
            stall      <= 1'b1;
            state      <= COMMIT;
          end else if (eret) begin
            r_h   <= 1'b1;
            stall <= 1'b1;
            state <= ERET_RD;
          end
        end
        COMMIT: begin
          exccode <= code_reg;
          exl     <= 1'b1;
          cnt     <= CNT_W'(FLUSH_CYCLES - 1);
          flush   <= 1'b1;
          state   <= FLUSH;
        end
        ERET_RD: begin
          target_reg <= epc_rdata;
          exl        <= 1'b0;
          cnt        <= CNT_W'(FLUSH_CYCLES - 1);
          flush      <= 1'b1;
          state      <= FLUSH;
        end
        FLUSH: begin
          if (cnt == '0) begin
            flush       <= 1'b0;
            redirect    <= 1'b1;
            redirect_pc <= target_reg;
            state       <= REDIRECT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REDIRECT: begin
          stall <= 1'b0;
          state <= IDLE;
        end
        default: begin
          stall <= 1'b0;
          flush <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] EXC = 32'h8000_0180;
  localparam int F = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  exc_vec = 7'd0;
  logic [31:0] pc_p = 32'd0;
  logic        bd_p = 1'b0;
  logic        eret = 1'b0;
  logic        mtc0_req = 1'b0;
  logic        mtc0_ack;
  logic [31:0] epc_rdata = 32'd0;
  logic        we_h, bd_h, r_h, exl, stall, flush, redirect;
  logic [31:0] pc_h, redirect_pc;
  logic [4:0]  exccode;

  cp0_exc_ctrl #(.EXC_VECTOR(EXC), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst(rst), .exc_vec(exc_vec), .pc_p(pc_p), .bd_p(bd_p), .eret(eret),
    .mtc0_req(mtc0_req), .mtc0_ack(mtc0_ack), .epc_rdata(epc_rdata),
    .we_h(we_h), .pc_h(pc_h), .bd_h(bd_h), .r_h(r_h), .exl(exl), .exccode(exccode),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a sequence is a numbered run of phases 1..F+2 after acceptance.
  bit          m_busy;
  int          m_k;
  bit          m_eret;
  logic        m_exl;
  logic [4:0]  m_code, l_code;
  logic [31:0] m_target, m_rpc, l_pc;
  logic        l_we, l_bd;
  logic        last_ack;

  int prio_bit[7]  = '{0, 1, 3, 4, 5, 6, 2};
  int prio_code[7] = '{0, 4, 10, 12, 8, 9, 5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_eret = 0; m_exl = 0; m_code = 0; l_code = 0;
    m_target = 0; m_rpc = 0; l_pc = 0; l_we = 0; l_bd = 0;
  endtask

  function automatic logic [6:0] masked_req();
    return exc_vec & {6'h3f, ~m_exl};
  endfunction

  function automatic logic exp_ack();
    return mtc0_req && !m_busy && (masked_req() == 7'd0) && !eret;
  endfunction

  task automatic model_step();
    logic [6:0] mv;
    if (!m_busy) begin
      mv = masked_req();
      if (mv != 7'd0) begin
        for (int i = 6; i >= 0; i--)
          if (mv[prio_bit[i]]) l_code = 5'(prio_code[i]);
        m_eret = 0; l_we = ~m_exl; l_pc = pc_p; l_bd = bd_p; m_target = EXC;
        m_busy = 1; m_k = 1;
        $display("txn exc code=%0d pc=%h bd=%0d epc_write=%0d", l_code, pc_p, bd_p, l_we);
      end else if (eret) begin
        m_eret = 1; m_busy = 1; m_k = 1;
      end
    end else begin
      if (m_k == 1) begin
        if (m_eret) begin
          m_exl = 0; m_target = epc_rdata;
          $display("txn eret target=%h", epc_rdata);
        end else begin
          m_exl = 1; m_code = l_code;
        end
      end
      if (m_k == F + 1) m_rpc = m_target;
      m_k++;
      if (m_k > F + 2) begin m_busy = 0; m_k = 0; end
    end
  endtask

  task automatic check_outputs();
    bit ph1_exc, ph1_eret;
    ph1_exc  = m_busy && m_k == 1 && !m_eret;
    ph1_eret = m_busy && m_k == 1 && m_eret;
    chk("stall", 32'(stall), 32'(m_busy));
    chk("we_h", 32'(we_h), 32'(ph1_exc && l_we));
    chk("pc_h", pc_h, ph1_exc ? l_pc : 32'd0);
    chk("bd_h", 32'(bd_h), 32'(ph1_exc && l_bd));
    chk("r_h", 32'(r_h), 32'(ph1_eret));
    chk("flush", 32'(flush), 32'(m_busy && m_k >= 2 && m_k <= F + 1));
    chk("redirect", 32'(redirect), 32'(m_busy && m_k == F + 2));
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("exl", 32'(exl), 32'(m_exl));
    chk("exccode", 32'(exccode), 32'(m_code));
  endtask

  // One clock cycle: drive at negedge, check ack, update model at posedge, check at next negedge.
  task automatic cyc(input logic [6:0] ev, input logic [31:0] pc, input logic bd,
                     input logic er, input logic req, input logic [31:0] rd);
    exc_vec = ev; pc_p = pc; bd_p = bd; eret = er; mtc0_req = req; epc_rdata = rd;
    #1;
    last_ack = mtc0_ack;
    chk("mtc0_ack", 32'(mtc0_ack), 32'(exp_ack()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0040_0024);
  endtask

  int saw_we;
  logic req_r;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_exl", 32'(exl), 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_exccode", 32'(exccode), 32'd0);
    rst = 1'b1;

    // Overflow from user mode
    cyc(7'h10, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t1_we_h", 32'(we_h), 32'd1);
    chk("t1_pc_h", pc_h, 32'h0040_0010);
    idle_cycles(1); chk("t1_flush_a", 32'(flush), 32'd1);
    idle_cycles(1); chk("t1_flush_b", 32'(flush), 32'd1);
    idle_cycles(1);
    chk("t1_redirect", 32'(redirect), 32'd1);
    chk("t1_redirect_pc", redirect_pc, 32'h8000_0180);
    chk("t1_exccode", 32'(exccode), 32'd12);
    chk("t1_exl", 32'(exl), 32'd1);
    idle_cycles(1);

    // ERET back to EPC
    cyc(7'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0040_0024);
    chk("t3_r_h", 32'(r_h), 32'd1);
    idle_cycles(3);
    chk("t3_redirect_pc", redirect_pc, 32'h0040_0024);
    chk("t3_exl", 32'(exl), 32'd0);
    idle_cycles(1);

    // int beats sys, delay slot flag passed through
    cyc(7'h21, 32'h0040_0100, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("t2_bd_h", 32'(bd_h), 32'd1);
    idle_cycles(3);
    chk("t2_exccode", 32'(exccode), 32'd0);
    idle_cycles(1);

    // exl=1: lone int ignored, ri enters without EPC write
    cyc(7'h01, 32'h0040_0200, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t5_int_ignored", 32'(stall), 32'd0);
    cyc(7'h08, 32'h0040_0204, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("t5_we_h", 32'(we_h), 32'd0);
    idle_cycles(3);
    chk("t5_redirect_pc", redirect_pc, 32'h8000_0180);
    chk("t5_exccode", 32'(exccode), 32'd10);
    idle_cycles(1);

    // MTC0 held across exception entry
    saw_we = 0;
    cyc(7'h40, 32'h0040_0300, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t4_ack_on_exc", 32'(last_ack), 32'd0);
    for (int i = 0; i < F + 2; i++) begin
      cyc(7'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);
      if (last_ack) saw_we++;
    end
    chk("t4_ack_while_busy", 32'(saw_we), 32'd0);
    cyc(7'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t4_ack_idle", 32'(last_ack), 32'd1);
    idle_cycles(1);

    // Asynchronous reset during flush
    cyc(7'h02, 32'h0040_0400, 1'b0, 1'b0, 1'b0, 32'd0);
    idle_cycles(1);
    chk("t6_pre_flush", 32'(flush), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_flush", 32'(flush), 32'd0);
    chk("t6_stall", 32'(stall), 32'd0);
    chk("t6_exl", 32'(exl), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(6);

    // Randomized traffic
    req_r = 1'b0;
    for (int n = 0; n < 800; n++) begin
      logic [6:0] ev;
      logic        er;
      ev = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'd0;
      er = ($urandom_range(0, 7) == 0);
      if (!(req_r && !last_ack)) req_r = ($urandom_range(0, 3) == 0);
      cyc(ev, $urandom, 1'($urandom), er, req_r, $urandom);
      if (last_ack) req_r = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
